// File: rtl/fan_controller_ramp.sv
// Multi-level fan speed controller with soft ramping.
// Button requests move a target level on the rising edge of `update`.
// The applied speed walks toward the target one level every RAMP_CYCLES clocks.
// Pressing up and down together is an emergency stop: it zeroes target and
// speed at once and skips the ramp.
module fan_controller_ramp #(
  parameter int SPEED_W     = 3,
  parameter int MAX_LEVEL   = 7,
  parameter int RAMP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               update,
  input  logic               down,
  input  logic               up,
  output logic [SPEED_W-1:0] speed,
  output logic [SPEED_W-1:0] target,
  output logic               ramping
);

  localparam int TIMER_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [SPEED_W-1:0] MAX_L      = SPEED_W'(MAX_LEVEL);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RAMP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               update_prev;
  logic               upd_edge;
  logic               req_stop;
  logic               req_inc;
  logic               req_dec;
  logic [SPEED_W-1:0] speed_inc;
  logic [SPEED_W-1:0] speed_dec;

  // Request decode from the rising edge of update, plus one-step neighbours of speed
  always_comb begin
    upd_edge  = update & ~update_prev;
    req_stop  = upd_edge & up & down;
    req_inc   = upd_edge & up & ~down;
    req_dec   = upd_edge & down & ~up;
    speed_inc = speed + 1'b1;
    speed_dec = speed - 1'b1;
  end

  assign ramping = (state != IDLE);

  // Edge detector, target tracking and ramp FSM.
  // The FSM reads the pre-edge target, so a target change is only seen on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      speed       <= '0;
      target      <= '0;
      state       <= IDLE;
      timer       <= '0;
      update_prev <= 1'b0;
    end else begin
      update_prev <= update;
      if (req_stop) begin
        speed  <= '0;
        target <= '0;
        state  <= IDLE;
        timer  <= '0;
      end else begin
        if (req_inc && (target != MAX_L)) begin
          target <= target + 1'b1;
        end else if (req_dec && (target != '0)) begin
          target <= target - 1'b1;
        end

        case (state)
          IDLE: begin
            if (speed < target) begin
              state <= RAMP_UP;
              timer <= '0;
            end else if (speed > target) begin
              state <= RAMP_DOWN;
              timer <= '0;
            end
          end

          RAMP_UP: begin
            if (target <= speed) begin
              timer <= '0;
              state <= (target == speed) ? IDLE : RAMP_DOWN;
            end else if (timer == TIMER_LAST) begin
              speed <= speed_inc;
              timer <= '0;
              if (speed_inc == target) state <= IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end

          RAMP_DOWN: begin
            if (target >= speed) begin
              timer <= '0;
              state <= (target == speed) ? IDLE : RAMP_UP;
            end else if (timer == TIMER_LAST) begin
              speed <= speed_dec;
              timer <= '0;
              if (speed_dec == target) state <= IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule
